// File: rtl/fetch_decode_unit.sv
// Four-cycle fetch/decode sequencer for a 16 x 9-bit instruction memory.
// Registers the decoded fields once per instruction and strobes the register-file write in WRITEBACK.
module fetch_decode_unit #(
  parameter int unsigned PC_WIDTH     = 4,
  parameter int unsigned INSTR_WIDTH  = 9,
  parameter bit          STOP_AT_WRAP = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic [PC_WIDTH-1:0]    programCounter,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic [1:0]             regReadAddrA,
  output logic [1:0]             regReadAddrB,
  output logic [1:0]             regWriteAddr,
  output logic                   regWriteEnable,
  output logic                   regWriteSelImm,
  output logic [3:0]             immediate,
  output logic [2:0]             aluOp,
  output logic                   busy,
  output logic                   halted,
  output logic [7:0]             retiredCount
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [2:0] OP_LI   = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [PC_WIDTH-1:0] PC_MAX = '1;
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  logic [2:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [2:0]             alu_op_q, alu_op_d;
  logic [1:0]             rs_q, rs_d;
  logic [1:0]             rt_q, rt_d;
  logic [1:0]             rd_q, rd_d;
  logic [3:0]             imm_q, imm_d;
  logic                   sel_imm_q, sel_imm_d;
  logic [7:0]             retired_q, retired_d;
  logic [2:0]             ir_opcode;

  assign ir_opcode = ir_q[INSTR_WIDTH-1 -: 3];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_op_d  = alu_op_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    sel_imm_d = sel_imm_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_op_d  = ir_opcode;
        rd_d      = ir_q[5:4];
        rs_d      = ir_q[3:2];
        rt_d      = ir_q[1:0];
        imm_d     = ir_q[3:0];
        sel_imm_d = (ir_opcode == OP_LI);
        state_d   = (ir_opcode == OP_HALT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        retired_d = retired_q + 8'd1;
        pc_d      = pc_q + PC_ONE;
        // A halt reached by wrapping leaves the PC at 0, unlike an opcode halt.
        state_d   = (STOP_AT_WRAP && (pc_q == PC_MAX)) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (run) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      alu_op_q  <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      sel_imm_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_op_q  <= alu_op_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      sel_imm_q <= sel_imm_d;
      retired_q <= retired_d;
    end
  end

  // Strobe is decoded from state flops so an asynchronous reset drops it at once.
  assign regWriteEnable = (state_q == S_WRITEBACK) && (alu_op_q != OP_NOP);
  assign programCounter = pc_q;
  assign regReadAddrA   = rs_q;
  assign regReadAddrB   = rt_q;
  assign regWriteAddr   = rd_q;
  assign regWriteSelImm = sel_imm_q;
  assign immediate      = imm_q;
  assign aluOp          = alu_op_q;
  assign busy           = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                          (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign halted         = (state_q == S_HALT);
  assign retiredCount   = retired_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: a program-walking model queues expected
// retirements/halts, and a negedge monitor compares them as the DUT produces them.
module tb_fetch_decode_unit;

  typedef struct {
    bit          is_halt;
    int unsigned pc, op, rd, rs, rt, imm;
    bit          we, sel;
    int unsigned npc, cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run0 = 1'b0, run1 = 1'b0;
  logic [8:0] mem0 [16];
  logic [8:0] mem1 [16];

  logic [3:0] pc0, pc1;
  logic [8:0] instr0, instr1;
  logic [1:0] ra0, rb0, wa0, ra1, rb1, wa1;
  logic       we0, sel0, busy0, halted0, we1, sel1, busy1, halted1;
  logic [3:0] imm0, imm1;
  logic [2:0] op0, op1;
  logic [7:0] cnt0, cnt1;

  assign instr0 = mem0[pc0];
  assign instr1 = mem1[pc1];

  fetch_decode_unit #(.PC_WIDTH(4), .INSTR_WIDTH(9), .STOP_AT_WRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .run(run0), .programCounter(pc0), .instruction(instr0),
    .regReadAddrA(ra0), .regReadAddrB(rb0), .regWriteAddr(wa0), .regWriteEnable(we0),
    .regWriteSelImm(sel0), .immediate(imm0), .aluOp(op0), .busy(busy0), .halted(halted0),
    .retiredCount(cnt0));

  fetch_decode_unit #(.PC_WIDTH(4), .INSTR_WIDTH(9), .STOP_AT_WRAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .programCounter(pc1), .instruction(instr1),
    .regReadAddrA(ra1), .regReadAddrB(rb1), .regWriteAddr(wa1), .regWriteEnable(we1),
    .regWriteSelImm(sel1), .immediate(imm1), .aluOp(op1), .busy(busy1), .halted(halted1),
    .retiredCount(cnt1));

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  ev_t exp_q[$];
  int unsigned model_cnt = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Walks the program as the instruction set defines it: one event per retired
  // instruction, ending with a halt event or after max_ret retirements.
  function automatic void model_run(input int unsigned start, input int unsigned max_ret);
    int unsigned pc = start;
    int unsigned n = 0;
    ev_t e;
    while (n < max_ret) begin
      logic [8:0] w = mem0[pc];
      e = '{default: 0};
      e.pc = pc;
      e.op = w[8:6];
      if (e.op == 7) begin
        e.is_halt = 1'b1;
        e.cnt = model_cnt;
        exp_q.push_back(e);
        return;
      end
      e.rd = w[5:4]; e.rs = w[3:2]; e.rt = w[1:0]; e.imm = w[3:0];
      e.we  = (e.op != 6);
      e.sel = (e.op == 5);
      pc = (pc + 1) % 16;
      model_cnt = (model_cnt + 1) % 256;
      e.npc = pc;
      e.cnt = model_cnt;
      exp_q.push_back(e);
      n++;
    end
  endfunction

  // Monitor: the snapshot from the previous negedge is the WRITEBACK cycle.
  logic [3:0] p_pc, p_imm;
  logic [2:0] p_op;
  logic [1:0] p_rd, p_rs, p_rt;
  logic       p_sel, p_halted;
  logic [7:0] p_cnt;
  int unsigned strobes;
  ev_t me;

  always @(negedge clk) begin
    if (!rst_n) begin
      strobes = 0; p_cnt = '0; p_halted = 1'b0;
    end else begin
      if (cnt0 != p_cnt) begin
        if (exp_q.size() == 0) chk("unexpected_retire", 1, 0);
        else begin
          me = exp_q.pop_front();
          chk("retire_kind", 0, me.is_halt);
          chk("wb_pc", p_pc, me.pc);
          chk("wb_aluop", p_op, me.op);
          if (me.op != 6) chk("wb_rd", p_rd, me.rd);
          if (me.op < 5) begin
            chk("wb_rs", p_rs, me.rs);
            chk("wb_rt", p_rt, me.rt);
          end
          chk("wb_imm", p_imm, me.imm);
          chk("wb_selimm", p_sel, me.sel);
          chk("wb_strobes", strobes, me.we);
          chk("next_pc", pc0, me.npc);
          chk("retired", cnt0, me.cnt);
        end
        strobes = 0;
      end
      if (halted0 && !p_halted) begin
        if (exp_q.size() == 0) chk("unexpected_halt", 1, 0);
        else begin
          me = exp_q.pop_front();
          chk("halt_kind", 1, me.is_halt);
          chk("halt_pc", pc0, me.pc);
          chk("halt_busy", busy0, 0);
          chk("halt_retired", cnt0, me.cnt);
        end
      end
      if (we0) strobes++;
      p_pc = pc0; p_op = op0; p_rd = wa0; p_rs = ra0; p_rt = rb0;
      p_imm = imm0; p_sel = sel0; p_cnt = cnt0; p_halted = halted0;
    end
  end

  task automatic pulse_run0(input int unsigned hold);
    @(negedge clk); run0 = 1'b1;
    repeat (hold) @(negedge clk);
    run0 = 1'b0;
  endtask

  task automatic wait_halt0(input string name, input int unsigned budget);
    int unsigned c = 0;
    while (!halted0 && c < budget) begin @(negedge clk); c++; end
    #2;
    chk(name, halted0, 1);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    for (int i = 0; i < 16; i++) begin mem0[i] = '0; mem1[i] = 9'b110_000000; end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pc", pc0, 0);  chk("rst_busy", busy0, 0); chk("rst_halted", halted0, 0);
    chk("rst_we", we0, 0);  chk("rst_cnt", cnt0, 0);   chk("rst_sel", sel0, 0);
    chk("rst_aluop", op0, 0); chk("rst_imm", imm0, 0);
    rst_n = 1'b1;

    // STOP_AT_WRAP instance: 16 nops then halt with PC wrapped to 0
    @(negedge clk); run1 = 1'b1;
    @(negedge clk); run1 = 1'b0;
    c = 0;
    while (!halted1 && c < 200) begin @(negedge clk); c++; end
    chk("wrap_cycles", c, 64);
    chk("wrap_halted", halted1, 1);
    chk("wrap_pc", pc1, 0);
    chk("wrap_retired", cnt1, 16);
    chk("wrap_we", we1, 0);

    // Directed program: li, add, nop, halt
    mem0[0] = 9'b101_00_0011;
    mem0[1] = 9'b000_00_01_10;
    mem0[2] = 9'b110_101010;
    mem0[3] = 9'b111_000000;
    model_run(0, 64);
    @(negedge clk); run0 = 1'b1;
    @(negedge clk); run0 = 1'b0;
    c = 0;
    while (pc0 == 0 && c < 20) begin @(negedge clk); c++; end
    chk("first_pc_step", c, 4);
    wait_halt0("dir_halt", 40);
    chk("dir_halt_pc", pc0, 3);
    model_run(0, 64);
    @(negedge clk); run0 = 1'b1;
    @(negedge clk); run0 = 1'b0;
    chk("restart_pc", pc0, 0);
    chk("restart_busy", busy0, 1);
    wait_halt0("restart_halt", 40);

    // Randomized programs with one halt; run sometimes held while busy
    for (int unsigned it = 0; it < 8; it++) begin
      int unsigned h = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
        logic [2:0] rop = 3'($urandom_range(0, 6));
        logic [5:0] rf  = 6'($urandom);
        mem0[i] = {rop, rf};
      end
      mem0[h][8:6] = 3'b111;
      model_run(0, 64);
      pulse_run0($urandom_range(1, 3));
      wait_halt0("rand_halt", (h + 1) * 4 + 20);
      chk("rand_halt_pc", pc0, h);
    end

    // All-nop loop without wrap-stop: PC cycles 15 -> 0, retiredCount wraps past 255
    for (int i = 0; i < 16; i++) mem0[i] = {3'b110, 6'($urandom)};
    model_run(0, 260);
    pulse_run0(1);
    c = 0;
    while (exp_q.size() != 0 && c < 1200) begin @(negedge clk); #2; c++; end
    chk("nop_loop_drained", exp_q.size(), 0);
    rst_n = 1'b0;
    exp_q.delete();
    model_cnt = 0;

    // run ignored while in reset
    run0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("inreset_busy", busy0, 0);
    chk("inreset_pc", pc0, 0);
    run0 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postreset_idle", busy0, 0);

    // Reset asserted mid-WRITEBACK of li r1,6
    mem0[0] = 9'b110_000000;
    mem0[1] = 9'b110_000000;
    mem0[2] = 9'b101_01_0110;
    mem0[3] = 9'b111_000000;
    model_run(0, 64);
    pulse_run0(1);
    c = 0;
    while (!(we0 && pc0 == 2) && c < 40) begin @(negedge clk); c++; end
    chk("li_strobe_seen", we0, 1);
    chk("li_wa", wa0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_we_drop", we0, 0);
    chk("async_pc", pc0, 0);
    chk("async_cnt", cnt0, 0);
    chk("async_busy", busy0, 0);
    exp_q.delete();
    model_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_run(0, 64);
    pulse_run0(1);
    wait_halt0("after_reset_halt", 40);
    chk("after_reset_pc", pc0, 3);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
